// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a ROWS x COLS matrix keypad one column at a time. Each column is
// driven low for SETTLE_CYCLES cycles. The debounced row lines are then
// sampled once. The lowest-index closed row on the driven column becomes
// the key code (row*COLS + col), which is offered on a valid/ready slot.
// After a detect the column stays driven until all rows have read high for
// SETTLE_CYCLES consecutive cycles, so one press yields exactly one code.
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   Defined   -> a held key re-issues its code every REPEAT_CYCLES cycles.
//   Undefined -> no repeat logic; one code per press.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   row_i      in   [ROWS] debounced row lines, active-low
//   col_o      out  [COLS] column drive, active-low, exactly one bit low
//   key_valid  out  key_code holds an unconsumed code
//   key_code   out  [4] row*COLS + col
//   key_ready  in   consumer accepts when key_valid && key_ready
//   key_drop   out  one-cycle pulse: detected code discarded, slot was full
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int unsigned COLS          = 4,
  parameter int unsigned ROWS          = 4,
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned REPEAT_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_i,
  output logic [COLS-1:0] col_o,
  output logic            key_valid,
  output logic [3:0]      key_code,
  input  logic            key_ready,
  output logic            key_drop
);

  localparam bit ParamsOk = (COLS >= 2) && (COLS <= 4) && (ROWS >= 2) && (ROWS <= 4) &&
                            (SETTLE_CYCLES >= 2) && (REPEAT_CYCLES >= 2);

  if (!ParamsOk) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  localparam int unsigned     CntW   = $clog2(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]      ColMax = 2'(COLS - 1);

  typedef enum logic {StScan, StHold} state_e;

  state_e          r_state;
  logic [1:0]      r_col;
  logic [CntW-1:0] r_cnt;
  logic            r_key_valid;
  logic [3:0]      r_key_code;
  logic            r_key_drop;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned      RcntW   = $clog2(REPEAT_CYCLES);
  localparam logic [RcntW-1:0] RcntMax = RcntW'(REPEAT_CYCLES - 1);

  logic [RcntW-1:0] r_rcnt;
  logic [3:0]       r_hold_code;
`endif

  logic       w_any_low;
  logic [1:0] w_row_idx;
  logic [3:0] w_code;
  logic [1:0] w_col_next;
  logic       w_slot_free;

  assign w_any_low   = ~(&row_i);
  assign w_col_next  = (r_col == ColMax) ? 2'd0 : r_col + 2'd1;
  // A code consumed on this very edge frees the slot for a new one.
  assign w_slot_free = ~r_key_valid | key_ready;
  assign w_code      = 4'({2'b00, w_row_idx} * 4'(COLS)) + {2'b00, r_col};

  // Lowest-index low row wins: scan downwards so the lowest match lands last.
  always_comb begin
    w_row_idx = 2'd0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_i[r]) begin
        w_row_idx = 2'(r);
      end
    end
  end

  // Column drive is a pure decode of the column register.
  always_comb begin
    col_o = '1;
    for (int c = 0; c < COLS; c++) begin
      col_o[c] = (r_col != 2'(c));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StScan;
      r_col       <= 2'd0;
      r_cnt       <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
      r_key_drop  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rcnt      <= '0;
      r_hold_code <= 4'd0;
`endif
    end else begin
      r_key_drop <= 1'b0;

      // Consumption first; a code loaded below on the same edge overrides it.
      if (r_key_valid && key_ready) begin
        r_key_valid <= 1'b0;
      end

      case (r_state)
        StScan: begin
          if (r_cnt == CntMax) begin
            r_cnt <= '0;
            if (w_any_low) begin
              r_state <= StHold;
              if (w_slot_free) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_code;
              end else begin
                r_key_drop <= 1'b1;
              end
`ifdef KEYPAD_REPEAT_EN
              r_rcnt      <= '0;
              r_hold_code <= w_code;
`endif
            end else begin
              r_col <= w_col_next;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        StHold: begin
          // r_cnt counts consecutive all-high cycles; any closed row restarts it.
          if (w_any_low) begin
            r_cnt <= '0;
          end else if (r_cnt == CntMax) begin
            r_state <= StScan;
            r_col   <= w_col_next;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end

`ifdef KEYPAD_REPEAT_EN
          if (!w_any_low) begin
            r_rcnt <= '0;
          end else if (r_rcnt == RcntMax) begin
            r_rcnt <= '0;
            if (w_slot_free) begin
              r_key_valid <= 1'b1;
              r_key_code  <= r_hold_code;
            end else begin
              r_key_drop <= 1'b1;
            end
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
`endif
        end

        default: begin
          r_state <= StScan;
        end
      endcase
    end
  end

  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_drop  = r_key_drop;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with COLS=ROWS=4, SETTLE_CYCLES=20. A keypad
// model turns a 16-bit "keys held" vector plus the driven column into row
// levels. Directed scenarios check the fixed timings; a randomized run
// compares every cycle against a behavioural model of the scan rules.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int COLS   = 4;
  localparam int ROWS   = 4;
  localparam int SETTLE = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        key_drop;

  logic [15:0] keys;  // bit r*COLS+c set = key (r,c) held closed

  int total = 0;
  int bad   = 0;

  // Behavioural model state (phase time counts 1..SETTLE)
  int m_col, m_time, m_valid, m_code, m_drop;
  bit m_hold;

  always #5 clk = ~clk;

  keypad_scanner #(
    .COLS          (COLS),
    .ROWS          (ROWS),
    .SETTLE_CYCLES (SETTLE),
    .REPEAT_CYCLES (500000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_i     (row_i),
    .col_o     (col_o),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_drop  (key_drop)
  );

  function automatic logic [3:0] col_lines(input int c);
    logic [3:0] one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic logic [3:0] rows_for(input logic [3:0] cols, input logic [15:0] k);
    logic [3:0] r = 4'hF;
    for (int ri = 0; ri < ROWS; ri++)
      for (int ci = 0; ci < COLS; ci++)
        if (cols[ci] == 1'b0 && k[ri*COLS+ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign row_i = rows_for(col_o, keys);

  task automatic model_reset();
    m_col = 0; m_time = 0; m_hold = 0; m_valid = 0; m_code = 0; m_drop = 0;
  endtask

  // Advance the model across one rising edge using current keys/key_ready.
  task automatic model_edge();
    logic [3:0] rows;
    int low_row;
    bit free;
    rows    = rows_for(col_lines(m_col), keys);
    low_row = -1;
    for (int r = ROWS - 1; r >= 0; r--) if (!rows[r]) low_row = r;
    free   = (m_valid == 0) || key_ready;
    m_drop = 0;
    if (m_valid != 0 && key_ready) m_valid = 0;
    if (!m_hold) begin
      m_time++;
      if (m_time == SETTLE) begin
        m_time = 0;
        if (low_row >= 0) begin
          m_hold = 1;
          if (free) begin m_valid = 1; m_code = low_row * COLS + m_col; end
          else m_drop = 1;
        end else begin
          m_col = (m_col + 1) % COLS;
        end
      end
    end else if (low_row >= 0) begin
      m_time = 0;
    end else begin
      m_time++;
      if (m_time == SETTLE) begin
        m_hold = 0; m_time = 0; m_col = (m_col + 1) % COLS;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    keys = '0; key_ready = 1'b1; rst_n = 1'b0;
    #12;
    total++; if (col_o !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b want=1110", col_o); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", key_valid); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", key_code); end
    total++; if (key_drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", key_drop); end
  endtask

  // Idle: each column held SETTLE cycles, full rotation, no codes.
  task automatic test_idle_scan();
    logic [3:0] exp;
    keys = '0; key_ready = 1'b1;
    do_reset();
    for (int n = 1; n <= 4 * SETTLE + 5; n++) begin
      tick();
      exp = col_lines((n / SETTLE) % COLS);
      total++;
      if (col_o !== exp || key_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_scan edge=%0d got col=%b v=%b want col=%b v=0", n, col_o, key_valid, exp);
      end
    end
  endtask

  // Key (2,1) from reset: code 9 after edge 40, consumed once, bounce on release.
  task automatic test_single_key();
    bit ok; int drops;
    keys = 16'h0001 << 9; key_ready = 1'b1;
    do_reset();
    for (int n = 1; n <= 39; n++) tick();
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL key_early got v=%b want 0", key_valid); end
    tick();
    total++;
    if (key_valid !== 1'b1 || key_code !== 4'd9 || col_o !== 4'b1101) begin
      bad++; $display("FAIL key_detect got v=%b code=%0d col=%b want v=1 code=9 col=1101",
                      key_valid, key_code, col_o);
    end
    tick();
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL key_consume got v=%b want 0", key_valid); end
    ok = 1; drops = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (key_valid !== 1'b0 || col_o !== 4'b1101) ok = 0;
      drops += int'(key_drop);
    end
    total++; if (!ok) begin bad++; $display("FAIL key_held_quiet got extra code/col move want none"); end
    keys = '0;
    for (int n = 0; n < 5; n++) begin tick(); if (col_o !== 4'b1101 || key_valid) ok = 0; end
    keys = 16'h0001 << 9;
    tick();
    keys = '0;
    for (int n = 0; n < SETTLE - 1; n++) begin
      tick(); if (col_o !== 4'b1101 || key_valid) ok = 0; drops += int'(key_drop);
    end
    total++; if (!ok) begin bad++; $display("FAIL bounce_hold got early release or code want col=1101"); end
    tick();
    total++; if (col_o !== 4'b1011) begin bad++; $display("FAIL bounce_release got col=%b want 1011", col_o); end
    total++; if (drops != 0) begin bad++; $display("FAIL bounce_drops got=%0d want 0", drops); end
  endtask

  // Slot full: code 0 stays, (3,3) detect pulses key_drop once.
  task automatic test_drop();
    bit stable; int drops; int drop_col_ok;
    keys = 16'h0001; key_ready = 1'b0;
    do_reset();
    for (int n = 1; n <= 20; n++) tick();
    total++;
    if (key_valid !== 1'b1 || key_code !== 4'd0) begin
      bad++; $display("FAIL drop_first got v=%b code=%0d want v=1 code=0", key_valid, key_code);
    end
    for (int n = 0; n < 10; n++) tick();
    keys = 16'h0001 << 15;
    stable = 1; drops = 0; drop_col_ok = 1;
    for (int n = 0; n < 150; n++) begin
      tick();
      if (key_valid !== 1'b1 || key_code !== 4'd0) stable = 0;
      if (key_drop === 1'b1) begin drops++; if (col_o !== 4'b0111) drop_col_ok = 0; end
    end
    total++; if (!stable) begin bad++; $display("FAIL drop_stable got slot changed want code 0 held"); end
    total++; if (drops != 1) begin bad++; $display("FAIL drop_count got=%0d want 1", drops); end
    total++; if (!drop_col_ok) begin bad++; $display("FAIL drop_col got drop off col3 want col=0111"); end
    key_ready = 1'b1;
    tick();
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL drop_xfer got v=%b want 0", key_valid); end
    stable = 1;
    for (int n = 0; n < 50; n++) begin tick(); if (key_valid !== 1'b0) stable = 0; end
    total++; if (!stable) begin bad++; $display("FAIL drop_single_xfer got extra code want none"); end
    keys = '0;
  endtask

  // Rows 1 and 3 closed on column 2: lowest row wins -> code 6 at edge 60.
  task automatic test_priority();
    int seen_at;
    keys = (16'h0001 << 6) | (16'h0001 << 14); key_ready = 1'b0;
    seen_at = -1;
    do_reset();
    for (int n = 1; n <= 100 && seen_at < 0; n++) begin
      tick();
      if (key_valid === 1'b1) seen_at = n;
    end
    total++; if (seen_at != 60) begin bad++; $display("FAIL prio_time got edge=%0d want 60", seen_at); end
    total++; if (key_code !== 4'd6) begin bad++; $display("FAIL prio_code got=%0d want 6", key_code); end
    keys = '0;
  endtask

  // Async reset during HOLD with a pending code.
  task automatic test_async_reset();
    int guard;
    keys = 16'h0001 << 1; key_ready = 1'b0;
    do_reset();
    guard = 0;
    while (key_valid !== 1'b1 && guard < 100) begin tick(); guard++; end
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL arst_setup got v=%b want 1", key_valid); end
    for (int n = 0; n < 5; n++) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (col_o !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 || key_drop !== 1'b0) begin
      bad++; $display("FAIL arst_values got col=%b v=%b code=%0d d=%b want 1110/0/0/0",
                      col_o, key_valid, key_code, key_drop);
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL arst_lost got v=%b want 0", key_valid); end
    keys = '0;
  endtask

  // Random presses, bounces and back-pressure vs the behavioural model.
  task automatic test_random();
    int dur; int sel; logic [3:0] exp_col;
    keys = '0; key_ready = 1'b1;
    do_reset();
    dur = 0;
    for (int n = 0; n < 3000; n++) begin
      if (dur == 0) begin
        sel = $urandom_range(9, 0);
        if (sel < 4) keys = '0;
        else if (sel < 9) keys = 16'h0001 << $urandom_range(15, 0);
        else keys = (16'h0001 << $urandom_range(15, 0)) | (16'h0001 << $urandom_range(15, 0));
        dur = (sel == 5) ? $urandom_range(3, 1) : $urandom_range(150, 1);
      end
      dur--;
      key_ready = ($urandom_range(3, 0) != 0);
      model_edge();
      tick();
      exp_col = col_lines(m_col);
      total++;
      if (col_o !== exp_col || key_valid !== m_valid[0] || key_drop !== m_drop[0] ||
          (m_valid != 0 && key_code !== m_code[3:0])) begin
        bad++;
        $display("FAIL random cyc=%0d got col=%b v=%b code=%0d d=%b want col=%b v=%0d code=%0d d=%0d",
                 n, col_o, key_valid, key_code, key_drop, exp_col, m_valid, m_code, m_drop);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_drop();
    test_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad scan controller for the keyboard front end. It drives one column of a ROWS×COLS keypad low at a time and waits a settle window. It then samples the already-debounced row lines and turns the first pressed key into a key code, offered downstream on a valid/ready handshake. It holds the column until the key is released, so each press yields exactly one code (optional auto-repeat).

## Interface
- COLS, 4, number of column drive lines (2..4)
- ROWS, 4, number of row sense lines (2..4); ROWS*COLS ≤ 16
- SETTLE_CYCLES, 20, cycles a column is driven before rows are sampled; also the release-stable window (≥ 2)
- REPEAT_CYCLES, 500000, auto-repeat period in cycles (used only with KEYPAD_REPEAT_EN)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- row_i  input  ROWS  debounced row lines, active-low (0 = key closed on driven column)
- col_o  output  COLS  column drive, active-low, exactly one bit low at any time
- key_valid  output  1  key_code holds an unconsumed code
- key_code  output  4  code = row*COLS + col, zero-extended
- key_ready  input  1  consumer accepts code when key_valid && key_ready
- key_drop  output  1  one-cycle pulse: a detected key was discarded because the output slot was full

## Operation
- States: SCAN, HOLD.
- SCAN: drive column `col` low; counter `cnt` runs 0..SETTLE_CYCLES-1. On the edge where cnt == SETTLE_CYCLES-1:
  - all row_i high → col advances (COLS-1 wraps to 0), cnt ← 0.
  - any row_i low → lowest-index low row wins, code = row*COLS + col, go to HOLD with same col, cnt ← 0.
- Code issue on detect: if slot free (key_valid=0, or key_valid && key_ready this cycle) → key_valid←1, key_code←code. Else → code discarded, key_drop pulses 1 cycle, still enter HOLD.
- HOLD: column stays driven. cnt counts consecutive cycles with all row_i high; any low row clears cnt. When cnt reaches SETTLE_CYCLES-1 with rows high → next column (wrap), SCAN, cnt ← 0.
- Handshake: key_valid stays 1 and key_code stable until key_valid && key_ready. Then key_valid ← 0 unless a new code is loaded the same edge, which wins.
- key_ready while key_valid=0 is ignored.

## Timing
- Reset values: col_o = all ones except bit 0 low; key_valid=0; key_code=0; key_drop=0; state SCAN, col=0, cnt=0.
- Reset assertion mid-operation aborts immediately (async) to these values; a pending code is lost.
- Column dwell in SCAN: exactly SETTLE_CYCLES cycles; full scan = COLS*SETTLE_CYCLES cycles.
- Detect latency: key_valid high after the sampling edge (cnt == SETTLE_CYCLES-1) of the key's column. Registered, no combinational path from row_i or key_ready to any output.
- Release latency: SETTLE_CYCLES consecutive all-high cycles in HOLD, then the next column is driven on the following edge.
- Row bounce in HOLD before release completes restarts the release window; no second code is issued.

## Configuration
- KEYPAD_REPEAT_EN defined: HOLD also runs repeat counter `rcnt` (width ≥ clog2(REPEAT_CYCLES)). It clears on HOLD entry and counts cycles with any row low.
  - At rcnt == REPEAT_CYCLES-1 → re-issue the held code under the same slot/drop rules, rcnt ← 0.
  - All rows high → rcnt holds at 0.
- KEYPAD_REPEAT_EN undefined: no repeat logic; one code per press.

## Test plan
(COLS=ROWS=4, SETTLE_CYCLES=20, key_ready=1 unless noted; edge 1 = first clk edge after rst_n rises.)
- Idle, no keys: col_o cycles 1110→1101→1011→0111→1110, each for 20 cycles; key_valid stays 0.
- Key (row 2, col 1) held from reset: key_valid=1, key_code=9 after edge 40. Consumed next edge; no further code while held.
- Same key released after 100 cycles, bouncing once at +5: exactly one code. col_o leaves 1101 only after 20 consecutive row-high cycles following the last bounce.
- key_ready=0, press (0,0) then release and press (3,3): first code 0 held stable, key_drop pulses once at the (3,3) detect. key_ready=1 then gives one transfer of code 0.
- Rows 1 and 3 low on col 2 together: key_code=6 (lowest row wins).
- rst_n low during HOLD with key_valid=1: outputs return to reset values immediately. With KEYPAD_REPEAT_EN and REPEAT_CYCLES=50, a held key re-issues its code every 50 cycles.
